// File: rtl/xswitch_nxn_rr.sv
// ---------------------------------------------------------------------------
// xswitch_nxn_rr
//   Parametrised NxN crossbar. Each input port pushes words into its own
//   FIFO; each output port holds one word in a register, filled by a
//   per-output round-robin arbiter over the FIFO heads that target it.
//
// Parameters
//   NPORTS      number of input and output ports (2..16)
//   DATA_W      data word width
//   ADDR_W      address width; destination = addr_in[DST_W-1:0]
//   FIFO_DEPTH  input FIFO depth per port (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   data_in    slice i = input port i word
//   addr_in    slice i = input port i address (low DST_W bits = output)
//   valid_in   input port i offers a word
//   rcv_rdy    input port i FIFO can accept (registered from FIFO count)
//   err_drop   one-cycle pulse: port i word dropped, destination >= NPORTS
//   data_out   slice j = word held in output j
//   addr_out   slice j = address of the held word, unchanged
//   valid_out  output j holds a word
//   data_rd    output j consumer pops the held word
//
// Handshake: an input word transfers on a rising edge where
// valid_in[i] & rcv_rdy[i]; otherwise the sender holds it. An output word
// leaves on a rising edge where valid_out[j] & data_rd[j]; data_rd while
// valid_out is low is ignored.
// ---------------------------------------------------------------------------
module xswitch_nxn_rr #(
    parameter int NPORTS     = 4,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS*DATA_W-1:0] data_in,
    input  logic [NPORTS*ADDR_W-1:0] addr_in,
    input  logic [NPORTS-1:0]        valid_in,
    output logic [NPORTS-1:0]        rcv_rdy,
    output logic [NPORTS-1:0]        err_drop,
    output logic [NPORTS*DATA_W-1:0] data_out,
    output logic [NPORTS*ADDR_W-1:0] addr_out,
    output logic [NPORTS-1:0]        valid_out,
    input  logic [NPORTS-1:0]        data_rd
);

    localparam int DST_W = (NPORTS <= 2) ? 1 : $clog2(NPORTS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage and control
    logic [DATA_W-1:0] r_fifo_data [NPORTS][FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr [NPORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr    [NPORTS];
    logic [PTR_W-1:0]  r_rd_ptr    [NPORTS];
    logic [CNT_W-1:0]  r_count     [NPORTS];
    logic [NPORTS-1:0] r_rcv_rdy;
    logic [NPORTS-1:0] r_err_drop;

    // Output registers and arbiter pointers
    logic [NPORTS-1:0] r_valid_out;
    logic [DATA_W-1:0] r_data_out [NPORTS];
    logic [ADDR_W-1:0] r_addr_out [NPORTS];
    logic [DST_W-1:0]  r_rr_ptr   [NPORTS];

    logic [NPORTS-1:0] w_accept;
    logic [NPORTS-1:0] w_dst_bad;
    logic [NPORTS-1:0] w_push;
    logic [NPORTS-1:0] w_pop;
    logic [NPORTS-1:0] w_nonempty;
    logic [NPORTS-1:0] w_out_free;
    logic [NPORTS-1:0] w_grant_any;
    logic [DATA_W-1:0] w_head_data [NPORTS];
    logic [ADDR_W-1:0] w_head_addr [NPORTS];
    logic [DST_W-1:0]  w_head_dst  [NPORTS];
    logic [NPORTS-1:0] w_req       [NPORTS];  // w_req[j][i]: input i head targets output j
    logic [DST_W-1:0]  w_win       [NPORTS];
    logic [DST_W-1:0]  w_rr_next   [NPORTS];
    logic [CNT_W-1:0]  w_cnt_next  [NPORTS];

    // Input side: accept, destination check, FIFO heads
    always_comb begin
        w_accept   = '0;
        w_dst_bad  = '0;
        w_push     = '0;
        w_nonempty = '0;
        for (int i = 0; i < NPORTS; i++) begin
            w_accept[i]    = valid_in[i] & r_rcv_rdy[i];
            // Widened by one bit so the compare is meaningful for any NPORTS.
            w_dst_bad[i]   = ({1'b0, addr_in[i*ADDR_W +: DST_W]} >= (DST_W+1)'(NPORTS));
            w_push[i]      = w_accept[i] & ~w_dst_bad[i];
            w_nonempty[i]  = (r_count[i] != '0);
            w_head_data[i] = r_fifo_data[i][r_rd_ptr[i]];
            w_head_addr[i] = r_fifo_addr[i][r_rd_ptr[i]];
            w_head_dst[i]  = r_fifo_addr[i][r_rd_ptr[i]][DST_W-1:0];
        end
    end

    // Request matrix and output availability
    always_comb begin
        w_out_free = '0;
        for (int j = 0; j < NPORTS; j++) begin
            w_req[j]      = '0;
            w_out_free[j] = ~r_valid_out[j] | data_rd[j];
            for (int i = 0; i < NPORTS; i++) begin
                w_req[j][i] = w_nonempty[i] && (w_head_dst[i] == DST_W'(i - i + j));
            end
        end
    end

    // Round-robin search per output, starting at r_rr_ptr[j]
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_any = '0;
        for (int j = 0; j < NPORTS; j++) begin
            w_win[j]     = '0;
            w_rr_next[j] = r_rr_ptr[j];
            for (int k = 0; k < NPORTS; k++) begin
                idx = int'(r_rr_ptr[j]) + k;
                if (idx >= NPORTS) begin
                    idx = idx - NPORTS;
                end
                if (w_out_free[j] && !w_grant_any[j] && w_req[j][idx]) begin
                    w_grant_any[j] = 1'b1;
                    w_win[j]       = DST_W'(idx);
                end
            end
            if (int'(w_win[j]) == NPORTS - 1) begin
                w_rr_next[j] = '0;
            end else begin
                w_rr_next[j] = w_win[j] + DST_W'(1);
            end
        end
    end

    // A head has a single destination, so at most one output pops each input.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NPORTS; i++) begin
            for (int j = 0; j < NPORTS; j++) begin
                if (w_grant_any[j] && (w_win[j] == DST_W'(i))) begin
                    w_pop[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            w_cnt_next[i] = r_count[i];
            if (w_push[i] && !w_pop[i]) begin
                w_cnt_next[i] = r_count[i] + CNT_W'(1);
            end else if (!w_push[i] && w_pop[i]) begin
                w_cnt_next[i] = r_count[i] - CNT_W'(1);
            end
        end
    end

    // FIFO storage needs no reset: the cleared count marks every slot empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (w_push[i]) begin
                r_fifo_data[i][r_wr_ptr[i]] <= data_in[i*DATA_W +: DATA_W];
                r_fifo_addr[i][r_wr_ptr[i]] <= addr_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORTS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rcv_rdy  <= '0;
            r_err_drop <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                r_count[i]    <= w_cnt_next[i];
                r_rcv_rdy[i]  <= (w_cnt_next[i] != CNT_W'(FIFO_DEPTH));
                r_err_drop[i] <= w_accept[i] & w_dst_bad[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_out <= '0;
            for (int j = 0; j < NPORTS; j++) begin
                r_data_out[j] <= '0;
                r_addr_out[j] <= '0;
                r_rr_ptr[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                if (w_grant_any[j]) begin
                    r_valid_out[j] <= 1'b1;
                    r_data_out[j]  <= w_head_data[w_win[j]];
                    r_addr_out[j]  <= w_head_addr[w_win[j]];
                    r_rr_ptr[j]    <= w_rr_next[j];
                end else if (data_rd[j]) begin
                    r_valid_out[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        data_out = '0;
        addr_out = '0;
        for (int j = 0; j < NPORTS; j++) begin
            data_out[j*DATA_W +: DATA_W] = r_data_out[j];
            addr_out[j*ADDR_W +: ADDR_W] = r_addr_out[j];
        end
    end

    assign valid_out = r_valid_out;
    assign rcv_rdy   = r_rcv_rdy;
    assign err_drop  = r_err_drop;

endmodule
